// File: rtl/clock_set_if.sv
// Button, live-time and control bundle between the clock-set controller and its
// surroundings: the master drives buttons and live time, the slave drives controls.
interface clock_set_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hour;
    logic [5:0] cur_minute;
    logic       run_en;
    logic       load;
    logic [3:0] load_hour;
    logic [5:0] load_minute;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output btn_mode, btn_inc, cur_hour, cur_minute,
        input  run_en, load, load_hour, load_minute, mode, blink
    );

    modport slave (
        input  btn_mode, btn_inc, cur_hour, cur_minute,
        output run_en, load, load_hour, load_minute, mode, blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set controller: RUN -> SET_HOUR -> SET_MINUTE -> COMMIT with debounced buttons,
// inc auto-repeat and a field blink. Optional idle abort: define CLKCTRL_SET_TIMEOUT_EN.
module clock_set_ctrl #(
    parameter logic [24:0] DEBOUNCE_CYCLES = 25'd500000,
    parameter logic [24:0] REPEAT_DELAY    = 25'd25000000,
    parameter logic [24:0] REPEAT_RATE     = 25'd5000000,
    parameter logic [24:0] BLINK_DIV       = 25'd12500000,
    parameter int          HOUR_MOD        = 12,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
) (
    input  logic        clk,
    input  logic        rst,
    clock_set_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        SET_HOUR   = 2'b01,
        SET_MINUTE = 2'b10,
        COMMIT     = 2'b11
    } state_t;

    localparam logic [4:0] HOUR_LIM = 5'(HOUR_MOD);
    localparam logic [3:0] HOUR_MAX = 4'(HOUR_MOD - 1);

    if (HOUR_MOD < 1 || HOUR_MOD > 16 || TIMEOUT_CYCLES == 32'd0) begin : g_param_check
        $error("clock_set_ctrl: HOUR_MOD must be 1..16 and TIMEOUT_CYCLES nonzero");
    end

    state_t      state, state_nxt;
    logic [1:0]  sync_a, sync_b, deb, deb_d;
    logic [24:0] db_cnt [2];
    logic [24:0] rep_cnt;
    logic        rep_arm, rep_first;
    logic [24:0] blink_cnt;
    logic        blink_r;
    logic [3:0]  hour;
    logic [5:0]  minute;
    logic        mode_pulse, inc_press, rep_pulse, inc_evt;
    logic        in_set, enter_set, timeout;

    // Bit 0 is the mode button, bit 1 the inc button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a    <= '0;
            sync_b    <= '0;
            deb       <= '0;
            deb_d     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync_a <= {bus.btn_inc, bus.btn_mode};
            sync_b <= sync_a;
            deb_d  <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - 25'd1) begin
                    deb[i]    <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 25'd1;
                end
            end
        end
    end

    assign mode_pulse = deb[0] & ~deb_d[0];
    assign inc_press  = deb[1] & ~deb_d[1];
    assign in_set     = (state == SET_HOUR) || (state == SET_MINUTE);
    assign rep_pulse  = rep_arm && deb[1] && in_set &&
                        (rep_cnt == (rep_first ? REPEAT_DELAY : REPEAT_RATE));
    assign inc_evt    = inc_press | rep_pulse;

    // Repeat only arms from a press that was actually accepted in a SET state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_arm   <= 1'b0;
            rep_first <= 1'b1;
        end else if (!in_set || !deb[1]) begin
            rep_cnt   <= '0;
            rep_arm   <= 1'b0;
            rep_first <= 1'b1;
        end else if (inc_press) begin
            rep_cnt   <= 25'd1;
            rep_arm   <= ~mode_pulse;
            rep_first <= 1'b1;
        end else if (rep_pulse) begin
            rep_cnt   <= 25'd1;
            rep_first <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt + 25'd1;
        end
    end

`ifdef CLKCTRL_SET_TIMEOUT_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!in_set || mode_pulse || inc_evt) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign timeout = in_set && (idle_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // A mode press always takes priority over the idle abort.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:        if (mode_pulse) state_nxt = SET_HOUR;
            SET_HOUR: begin
                if (mode_pulse)   state_nxt = SET_MINUTE;
                else if (timeout) state_nxt = RUN;
            end
            SET_MINUTE: begin
                if (mode_pulse)   state_nxt = COMMIT;
                else if (timeout) state_nxt = RUN;
            end
            COMMIT:     state_nxt = RUN;
            default:    state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour   <= '0;
            minute <= '0;
        end else begin
            case (state)
                RUN: if (mode_pulse) begin
                    hour   <= ({1'b0, bus.cur_hour} >= HOUR_LIM) ? 4'd0 : bus.cur_hour;
                    minute <= (bus.cur_minute > 6'd59) ? 6'd0 : bus.cur_minute;
                end
                SET_HOUR: if (inc_evt && !mode_pulse) begin
                    hour <= (hour == HOUR_MAX) ? 4'd0 : hour + 4'd1;
                end
                SET_MINUTE: if (inc_evt && !mode_pulse) begin
                    minute <= (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign enter_set = (state_nxt != state) &&
                       ((state_nxt == SET_HOUR) || (state_nxt == SET_MINUTE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_r   <= 1'b0;
        end else if (enter_set) begin
            blink_cnt <= '0;
            blink_r   <= 1'b1;
        end else if (in_set) begin
            if (blink_cnt == BLINK_DIV - 25'd1) begin
                blink_cnt <= '0;
                blink_r   <= ~blink_r;
            end else begin
                blink_cnt <= blink_cnt + 25'd1;
            end
        end else begin
            blink_cnt <= '0;
            blink_r   <= 1'b0;
        end
    end

    assign bus.run_en      = (state == RUN);
    assign bus.load        = (state == COMMIT);
    assign bus.mode        = state;
    assign bus.blink       = blink_r & in_set;
    assign bus.load_hour   = hour;
    assign bus.load_minute = minute;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-set controller for the digital clock counter block; sits between the debounced-button inputs and the hour/minute/second counters.
- Sequences RUN -> SET_HOUR -> SET_MINUTE -> COMMIT using two push buttons (mode, inc), with auto-repeat on inc.
- While setting, the counter is held and edited values are shown on the display; COMMIT issues a one-cycle load strobe.

Parameters:
- DEBOUNCE_CYCLES, 25'd500000: cycles a synchronised button level must be stable before it is accepted.
- REPEAT_DELAY, 25'd25000000: cycles inc must be held before auto-repeat starts.
- REPEAT_RATE, 25'd5000000: cycles between auto-repeat increments.
- BLINK_DIV, 25'd12500000: half-period of the blink output, in cycles.
- HOUR_MOD, 12: hour range is 0..HOUR_MOD-1; must be <= 16.
- TIMEOUT_CYCLES, 32'd500000000: idle abort time; used only with CLKCTRL_SET_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_mode  in  1  raw mode button, asynchronous to clk.
- btn_inc  in  1  raw increment button, asynchronous to clk.
- cur_hour  in  4  live hour from the clock counter.
- cur_minute  in  6  live minute from the clock counter.
- run_en  out  1  counter enable; 1 only in RUN.
- load  out  1  one-cycle strobe; counter loads load_hour/load_minute and clears seconds.
- load_hour  out  4  hour value to load; equals edit hour.
- load_minute  out  6  minute value to load; equals edit minute.
- mode  out  2  state code: 00 RUN, 01 SET_HOUR, 10 SET_MINUTE, 11 COMMIT.
- blink  out  1  display blink for the field being edited.

Behaviour:
- Reset (async, any state, including mid-edit):
  - state=RUN, run_en=1, load=0, mode=00, blink=0.
  - load_hour=0, load_minute=0.
  - All counters and synchronisers cleared.
  - No load is issued; any edit in progress is discarded.
- Input conditioning:
  - Each button passes through a 2-FF synchroniser, then a debouncer.
  - The debounced level changes only after the synchronised level has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - A press event is a 1-cycle pulse on the debounced 0->1 edit. Total latency from a clean raw edge is DEBOUNCE_CYCLES+2 cycles, +/-1.
- Auto-repeat:
  - While debounced inc stays 1 in a SET state, a repeat pulse fires REPEAT_DELAY cycles after the press, then every REPEAT_RATE cycles.
  - Release stops repeat immediately. Repeat is ignored in RUN.
- State machine (transitions occur on the cycle after the event pulse):
  - RUN + mode press:
    - Capture cur_hour into the hour register and cur_minute into the minute register.
    - A captured value out of range (hour>=HOUR_MOD, minute>59) is clamped to 0.
    - Go to SET_HOUR; run_en=0 from that cycle.
  - SET_HOUR + inc press/repeat: hour = (hour==HOUR_MOD-1) ? 0 : hour+1.
  - SET_HOUR + mode press: go to SET_MINUTE.
  - SET_MINUTE + inc press/repeat: minute = (minute==59) ? 0 : minute+1.
  - SET_MINUTE + mode press: go to COMMIT.
  - COMMIT: lasts exactly 1 cycle with load=1, then returns to RUN.
    - run_en=0 in COMMIT and returns to 1 in RUN.
    - The counter is frozen during COMMIT, so the load takes effect with no lost or extra seconds.
- Simultaneous events:
  - mode and inc pulses in the same cycle: mode wins, inc is dropped.
  - Only one increment is applied per cycle.
- Blink:
  - Counter restarts at 0 with blink=1 on entry to each SET state.
  - Toggles every BLINK_DIV cycles.
  - Forced to 0 in RUN and COMMIT.
- load_hour/load_minute always reflect the edit registers, so the display mux may show them in SET states.

Optional Feature:
- Macro: CLKCTRL_SET_TIMEOUT_EN.
- Defined:
  - An idle counter runs in the SET states and is cleared by any mode/inc pulse (including repeat).
  - When it reaches TIMEOUT_CYCLES, the block returns to RUN with no load pulse; edits are discarded and run_en=1 on the next cycle.
  - If the timeout and a mode press coincide, the press wins.
- Undefined: no idle counter; SET states persist indefinitely.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, BLINK_DIV=3, HOUR_MOD=12, TIMEOUT_CYCLES=100.
- Reset/idle: assert rst mid-cycle -> outputs are at reset values immediately. After release with no buttons: run_en=1, mode=00, load never pulses.
- Full set: cur_hour=11, cur_minute=59; mode press, inc press, mode press, inc press, mode press.
  - Required: wraps to hour 0 then minute 0.
  - Exactly one load pulse with load_hour=0, load_minute=0.
  - run_en low from the capture cycle through COMMIT.
- Bounce: btn_mode toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one transition RUN->SET_HOUR.
- Auto-repeat: in SET_MINUTE at minute 10, hold inc for 45 cycles after debounce -> minute=16 (1 press + 5 repeats).
  - Release -> no further increments.
- Simultaneous: inject mode and inc pulses in the same cycle in SET_HOUR -> state goes to SET_MINUTE, hour unchanged.
- Timeout (macro defined): enter SET_HOUR, no input for 100 cycles -> mode=00, run_en=1, no load pulse.
  - With macro undefined: still in SET_HOUR after 1000 cycles.
